// File: rtl/stack_pkg.sv
// Shared types and constants for the RPN stack sequencer.
package stack_pkg;

  localparam int unsigned STACK_DEPTH = 128;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [2:0] {
    OP_PUSHI = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_DUP   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_UNDER   = 2'd1,
    ERR_OVER    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_POPA_REQ  = 4'd1,
    ST_POPA_WAIT = 4'd2,
    ST_POPB_REQ  = 4'd3,
    ST_POPB_WAIT = 4'd4,
    ST_EXEC      = 4'd5,
    ST_PUSH_REQ  = 4'd6,
    ST_PUSH_WAIT = 4'd7,
    ST_RESP      = 4'd8
  } state_e;

endpackage

// File: rtl/stack_rpn_alu.sv
// Combinational binary-op unit: result = b op a (b is the deeper operand).
module stack_rpn_alu
  import stack_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  logic [W:0] sum;

  // Operation select; carry is add carry-out or subtract borrow, else 0
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        sum    = {1'b0, b} + {1'b0, a};
        result = sum[W-1:0];
        carry  = sum[W];
      end
      OP_SUB: begin
        result = b - a;
        carry  = (a > b);
      end
      OP_AND:  result = b & a;
      OP_OR:   result = b | a;
      OP_XOR:  result = b ^ a;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/stack_rpn_sequencer.sv
// Turns RPN host commands into single-cycle push/pop transactions on an
// external stack, tracking depth locally so bad commands never reach it.
module stack_rpn_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH   = STACK_DEPTH,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned W       = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [W-1:0]           cmd_imm,
  output logic                   rsp_valid,
  output logic [W-1:0]           rsp_data,
  output logic [1:0]             rsp_err,
  output logic                   rsp_zero,
  output logic                   rsp_carry,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [W-1:0]           stk_wdata,
  input  logic [W-1:0]           stk_rdata,
  input  logic                   stk_done,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   fault
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  err_e           rsp_err_q, rsp_err_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   stk_wdata_q, stk_wdata_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           fault_q, fault_d;
  logic           zero_pend_q, zero_pend_d;
  logic           carry_pend_q, carry_pend_d;
  logic           push_cnt_q, push_cnt_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           stk_push_q, stk_push_d;
  logic           stk_pop_q, stk_pop_d;

  op_e            acc_op;
  logic           underflow, overflow, in_wait, timed_out;
  logic [W-1:0]   alu_result;
  logic           alu_carry, alu_zero;

  stack_rpn_alu #(.W(W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Acceptance-time depth checks and wait-state timer status
  always_comb begin
    acc_op    = op_e'(cmd_op);
    underflow = 1'b0;
    overflow  = 1'b0;
    case (acc_op)
      OP_PUSHI: overflow = (depth_q >= DW'(DEPTH));
      OP_POP:   underflow = (depth_q == '0);
      OP_DUP: begin
        underflow = (depth_q == '0);
        overflow  = (depth_q >= DW'(DEPTH));
      end
      default:  underflow = (depth_q < DW'(2));
    endcase
    in_wait   = (state_q == ST_POPA_WAIT) || (state_q == ST_POPB_WAIT) ||
                (state_q == ST_PUSH_WAIT);
    timed_out = (timer_q >= TW'(TIMEOUT - 1));
  end

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rsp_err_d    = rsp_err_q;
    depth_d      = depth_q;
    timer_d      = timer_q;
    a_d          = a_q;
    b_d          = b_q;
    stk_wdata_d  = stk_wdata_q;
    rsp_data_d   = rsp_data_q;
    fault_d      = fault_q;
    zero_pend_d  = zero_pend_q;
    carry_pend_d = carry_pend_q;
    push_cnt_d   = push_cnt_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = acc_op;
          push_cnt_d = 1'b0;
          if (underflow) begin
            rsp_err_d = ERR_UNDER;
            state_d   = ST_RESP;
          end else if (overflow) begin
            rsp_err_d = ERR_OVER;
            state_d   = ST_RESP;
          end else if (acc_op == OP_PUSHI) begin
            stk_wdata_d  = cmd_imm;
            zero_pend_d  = (cmd_imm == '0);
            carry_pend_d = 1'b0;
            state_d      = ST_PUSH_REQ;
          end else begin
            state_d = ST_POPA_REQ;
          end
        end
      end
      ST_POPA_REQ: begin
        timer_d = TW'(1);
        state_d = ST_POPA_WAIT;
      end
      ST_POPA_WAIT: begin
        if (stk_done) begin
          depth_d = depth_q - DW'(1);
          a_d     = stk_rdata;
          if (op_q == OP_POP) begin
            rsp_data_d  = stk_rdata;
            rsp_zero_d  = (stk_rdata == '0);
            rsp_carry_d = 1'b0;
            rsp_err_d   = ERR_OK;
            state_d     = ST_RESP;
          end else if (op_q == OP_DUP) begin
            stk_wdata_d  = stk_rdata;
            zero_pend_d  = (stk_rdata == '0);
            carry_pend_d = 1'b0;
            state_d      = ST_PUSH_REQ;
          end else begin
            state_d = ST_POPB_REQ;
          end
        end
      end
      ST_POPB_REQ: begin
        timer_d = TW'(1);
        state_d = ST_POPB_WAIT;
      end
      ST_POPB_WAIT: begin
        if (stk_done) begin
          depth_d = depth_q - DW'(1);
          b_d     = stk_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        stk_wdata_d  = alu_result;
        zero_pend_d  = alu_zero;
        carry_pend_d = alu_carry;
        state_d      = ST_PUSH_REQ;
      end
      ST_PUSH_REQ: begin
        timer_d = TW'(1);
        state_d = ST_PUSH_WAIT;
      end
      ST_PUSH_WAIT: begin
        if (stk_done) begin
          depth_d = depth_q + DW'(1);
          if ((op_q == OP_DUP) && !push_cnt_q) begin
            push_cnt_d = 1'b1;
            state_d    = ST_PUSH_REQ;
          end else begin
            rsp_data_d  = stk_wdata_q;
            rsp_zero_d  = zero_pend_q;
            rsp_carry_d = carry_pend_q;
            rsp_err_d   = ERR_OK;
            state_d     = ST_RESP;
          end
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Shared watchdog for all wait states; a completion always wins
    if (in_wait && !stk_done) begin
      if (timed_out) begin
        fault_d   = 1'b1;
        rsp_err_d = ERR_TIMEOUT;
        state_d   = ST_RESP;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    stk_push_d  = (state_d == ST_PUSH_REQ);
    stk_pop_d   = (state_d == ST_POPA_REQ) || (state_d == ST_POPB_REQ);
    rsp_valid_d = (state_d == ST_RESP);
    cmd_ready_d = (state_d == ST_IDLE) && !fault_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_PUSHI;
      rsp_err_q    <= ERR_OK;
      depth_q      <= '0;
      timer_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      stk_wdata_q  <= '0;
      rsp_data_q   <= '0;
      fault_q      <= 1'b0;
      zero_pend_q  <= 1'b0;
      carry_pend_q <= 1'b0;
      push_cnt_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      stk_push_q   <= 1'b0;
      stk_pop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rsp_err_q    <= rsp_err_d;
      depth_q      <= depth_d;
      timer_q      <= timer_d;
      a_q          <= a_d;
      b_q          <= b_d;
      stk_wdata_q  <= stk_wdata_d;
      rsp_data_q   <= rsp_data_d;
      fault_q      <= fault_d;
      zero_pend_q  <= zero_pend_d;
      carry_pend_q <= carry_pend_d;
      push_cnt_q   <= push_cnt_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_valid_q  <= rsp_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      stk_push_q   <= stk_push_d;
      stk_pop_q    <= stk_pop_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_wdata = stk_wdata_q;
  assign depth     = depth_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench for stack_rpn_sequencer: behavioural stack device plus a reference
// model of RPN command semantics (queue based), random and directed traffic.
module tb_stack_rpn_sequencer;

  localparam int DEPTH   = 128;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_done;
  logic [7:0] depth;
  logic       fault;

  stack_rpn_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_done(stk_done),
    .depth(depth), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stack device model state
  logic [7:0] phys_stk[$];
  int  lat_cfg   = 1;     // 0 means the device never completes
  int  n_push    = 0;
  int  n_pop     = 0;
  int  dual_cnt  = 0;
  int  spur_cnt  = 0;
  int  spur_seen = 0;
  bit  pend;
  bit  pend_push;
  int  wait_cnt;

  // Reference model of the host-visible stack
  logic [7:0] ref_stk[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Stack device: completes each request lat_cfg cycles later
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      pend      = 1'b0;
      stk_done  = 1'b0;
      stk_rdata = 8'h00;
      phys_stk.delete();
    end else begin
      stk_done  = 1'b0;
      stk_rdata = 8'($urandom);
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        stk_done  = 1'b1;
      end
      if (pend) begin
        if (wait_cnt <= 1) begin
          stk_done = 1'b1;
          if (pend_push) begin
            phys_stk.push_back(stk_wdata);
          end else if (phys_stk.size() > 0) begin
            stk_rdata = phys_stk.pop_back();
          end
          pend = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (stk_push || stk_pop) begin
        if (stk_push) n_push++;
        if (stk_pop) n_pop++;
        if (stk_push && stk_pop) dual_cnt++;
        if (lat_cfg != 0) begin
          pend      = 1'b1;
          wait_cnt  = lat_cfg;
          pend_push = stk_push;
        end
      end
    end
  end

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(rsp_data), 32'd0);
    chk({tag, "_req"},   32'({stk_push, stk_pop}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    @(negedge clk);
  endtask

  // Issue one command at a negedge; model predicts response, latency and traffic
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm, input int lat);
    int cyc, p0, q0, n, need, e_err, e_lat, e_push, e_pop, s, a, b, r, c;
    bit grows, binop;
    lat_cfg = lat;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    p0 = n_push; q0 = n_pop;
    n = ref_stk.size();
    binop = (op >= 3'd2) && (op <= 3'd6);
    need  = (op == 3'd0) ? 0 : ((op == 3'd1 || op == 3'd7) ? 1 : 2);
    grows = (op == 3'd0) || (op == 3'd7);
    e_push = 0; e_pop = 0; r = 0; c = 0;
    if (n < need) e_err = 1;
    else if (grows && n >= DEPTH) e_err = 2;
    else if (lat == 0) begin
      e_err = 3;
      if (op == 3'd0) e_push = 1; else e_pop = 1;
    end else begin
      e_err = 0;
      case (op)
        3'd0: begin r = int'(imm); ref_stk.push_back(imm); e_push = 1; end
        3'd1: begin r = int'(ref_stk.pop_back()); e_pop = 1; end
        3'd7: begin r = int'(ref_stk[$]); ref_stk.push_back(8'(r)); e_pop = 1; e_push = 2; end
        default: begin
          a = int'(ref_stk.pop_back());
          b = int'(ref_stk.pop_back());
          case (op)
            3'd2: begin s = b + a; r = s & 255; c = (s > 255) ? 1 : 0; end
            3'd3: begin r = (b - a) & 255; c = (a > b) ? 1 : 0; end
            3'd4: r = b & a;
            3'd5: r = b | a;
            default: r = b ^ a;
          endcase
          ref_stk.push_back(8'(r));
          e_pop = 2; e_push = 1;
        end
      endcase
    end
    if (e_err == 3) e_lat = 1 + TIMEOUT;
    else if (e_err != 0) e_lat = 1;
    else e_lat = (e_push + e_pop) * (1 + lat) + (binop ? 1 : 0) + 1;

    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_imm = 8'($urandom);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    if (e_err == 0) begin
      chk("rsp_data",  32'(rsp_data), 32'(r));
      chk("rsp_zero",  32'(rsp_zero), (r == 0) ? 32'd1 : 32'd0);
      chk("rsp_carry", 32'(rsp_carry), 32'(c));
    end
    chk("depth", 32'(depth), 32'(ref_stk.size()));
    chk("n_push", 32'(n_push - p0), 32'(e_push));
    chk("n_pop",  32'(n_pop - q0), 32'(e_pop));
    chk("phys_size", 32'(phys_stk.size()), 32'(ref_stk.size()));
    if (ref_stk.size() > 0 && phys_stk.size() > 0)
      chk("phys_top", 32'(phys_stk[$]), 32'(ref_stk[$]));
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int cyc, q0;
    bit saw_rsp;
    logic [2:0] op;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'd0;
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // Basic add
    do_cmd(3'd0, 8'h05, 1);
    do_cmd(3'd0, 8'h03, 1);
    do_cmd(3'd2, 8'h00, 1);
    chk("add53_data", 32'(rsp_data), 32'h08);
    chk("add53_carry", 32'(rsp_carry), 32'd0);
    chk("add53_depth", 32'(depth), 32'd1);

    // Carry and borrow
    do_cmd(3'd0, 8'hF0, 1);
    do_cmd(3'd0, 8'h20, 1);
    do_cmd(3'd2, 8'h00, 2);
    chk("addc_data", 32'(rsp_data), 32'h10);
    chk("addc_carry", 32'(rsp_carry), 32'd1);
    do_cmd(3'd0, 8'h11, 1);
    do_cmd(3'd3, 8'h00, 1);
    chk("sub_data", 32'(rsp_data), 32'hFF);
    chk("sub_borrow", 32'(rsp_carry), 32'd1);

    // Underflow from empty, then fill to overflow
    do_reset("rst1");
    do_cmd(3'd1, 8'h00, 1);
    chk("uf_err", 32'(rsp_err), 32'd1);
    while (ref_stk.size() < DEPTH) do_cmd(3'd0, 8'($urandom), 1);
    do_cmd(3'd0, 8'h77, 1);
    chk("of_err", 32'(rsp_err), 32'd2);
    chk("of_depth", 32'(depth), 32'd128);
    do_cmd(3'd7, 8'h00, 1);

    // DUP then drain
    do_reset("rst2");
    do_cmd(3'd0, 8'h2A, 1);
    do_cmd(3'd7, 8'h00, 1);
    chk("dup_depth", 32'(depth), 32'd2);
    do_cmd(3'd1, 8'h00, 1);
    do_cmd(3'd1, 8'h00, 3);
    chk("dup_pop2", 32'(rsp_data), 32'h2A);
    chk("dup_zero", 32'(rsp_zero), 32'd0);
    chk("dup_depth0", 32'(depth), 32'd0);

    // Timeout: device never answers a push
    do_cmd(3'd0, 8'h44, 0);
    chk("to_fault", 32'(fault), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("to_ready_stuck", 32'(cmd_ready), 32'd0);
    end
    lat_cfg = 1;
    do_reset("rst3");

    // Reset during the second pop of an ADD
    do_cmd(3'd0, 8'h09, 1);
    do_cmd(3'd0, 8'h0A, 1);
    lat_cfg = 4;
    q0 = n_pop;
    cmd_valid = 1'b1; cmd_op = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (n_pop < q0 + 2 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("midop_second_pop", 32'(n_pop - q0), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rspv", 32'(rsp_valid), 32'd0);
    saw_rsp = 1'b0;
    do_reset("rst4");
    // Spurious completion while idle
    spur_cnt++;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("spur_rsp", 32'(saw_rsp), 32'd0);
    chk("spur_depth", 32'(depth), 32'd0);
    chk("spur_ready", 32'(cmd_ready), 32'd1);
    do_cmd(3'd0, 8'h00, 1);
    do_cmd(3'd1, 8'h00, 1);
    chk("zero_pop", 32'(rsp_zero), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 3'd0;
      do_cmd(op, 8'($urandom), int'($urandom_range(1, 3)));
    end

    chk("no_dual_req", 32'(dual_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_rpn_sequencer.md
Name: stack_rpn_sequencer

Overview:
- Host-side command sequencer that sits directly upstream of the 128-entry push/pop stack and drives its push, pop and data-bus handshake.
- Accepts RPN commands (push immediate, pop, binary ALU ops, dup).
- Turns each command into the required sequence of single-cycle stack pushes and pops, and returns results and flags to the host.
- Tracks stack depth locally, so underflow and overflow are rejected before any stack traffic is issued.

Parameters:
- DEPTH, 128, number of stack entries; the depth counter is $clog2(DEPTH)+1 bits wide.
- TIMEOUT, 15, maximum cycles to wait for stk_done after a request before a fault is declared.
- W, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0 PUSHI, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 DUP.
- cmd_imm  in  W  immediate operand for PUSHI.
- rsp_valid  out  1  one-cycle pulse: command finished.
- rsp_data  out  W  popped value (POP) or pushed result (ALU ops, DUP, PUSHI).
- rsp_err  out  2  0 ok, 1 underflow, 2 overflow, 3 timeout; valid with rsp_valid.
- rsp_zero  out  1  rsp_data == 0.
- rsp_carry  out  1  carry-out for ADD, borrow for SUB, 0 for all other ops.
- stk_push  out  1  one-cycle push request to the stack.
- stk_pop  out  1  one-cycle pop request to the stack.
- stk_wdata  out  W  push data; stable from request until done.
- stk_rdata  in  W  stack top data; sampled in the stk_done cycle of a pop.
- stk_done  in  1  stack completion strobe.
- depth  out  $clog2(DEPTH)+1  current local depth count.
- fault  out  1  sticky timeout fault.

Behaviour:
- Reset (async assert, sync deassert on the clk edge):
  - state IDLE, depth 0, fault 0.
  - All outputs 0, except cmd_ready, which is 1.
  - Reset mid-operation abandons the command with no response; the stack must be reset in the same cycle.
- cmd_ready = (state == IDLE) && !fault. A command is accepted on cmd_valid && cmd_ready; cmd_op and cmd_imm are latched at acceptance.
- Depth check, done in the acceptance cycle; the next cycle goes straight to RESP with the error, no stack traffic, depth unchanged:
  - POP and DUP need depth >= 1.
  - Binary ops (ADD, SUB, AND, OR, XOR) need depth >= 2.
  - PUSHI and DUP need depth < DEPTH.
  - Underflow takes precedence over overflow.
- States: IDLE, POPA_REQ, POPA_WAIT, POPB_REQ, POPB_WAIT, EXEC, PUSH_REQ, PUSH_WAIT, RESP.
- Request rules:
  - Each *_REQ state drives stk_push or stk_pop high for exactly one cycle, then enters *_WAIT.
  - Never both requests in the same cycle.
  - stk_done seen in the REQ cycle itself is ignored; stk_done outside any WAIT state is ignored.
- WAIT: the timer counts cycles. On stk_done the FSM advances. When the timer reaches TIMEOUT with no stk_done: set fault, RESP with err 3, and cmd_ready stays 0 until reset.
- Sequences:
  - PUSHI: PUSH(imm).
  - POP: POPA, then RESP with rsp_data = A.
  - Binary op: POPA (A = top), POPB, EXEC computes B op A, then PUSH(result).
  - DUP: POPA, PUSH(A), PUSH(A), driven by a 1-bit push counter.
- Arithmetic:
  - ADD: {carry, result} = B + A, (W+1)-bit.
  - SUB: result = B - A; borrow = (A > B).
  - Result truncated to W bits.
- depth updates on each completed stk_done: +1 per push, -1 per pop.
- RESP lasts one cycle with rsp_valid = 1, then returns to IDLE. A new command can be accepted the cycle after RESP.
- rsp_data, rsp_zero and rsp_carry hold their last values between responses.
- Latency for PUSHI with stk_done one cycle after the request: accept cycle, REQ, WAIT, RESP, so rsp_valid is 3 cycles after acceptance.

Decomposition:
- Package stack_pkg holds:
  - the op_e enum (3-bit codes above);
  - the err_e enum;
  - the state_e enum;
  - constants STACK_DEPTH = 128 and DATA_W = 8.
- One sub-module, stack_rpn_alu: purely combinational; inputs op, a, b; outputs result, carry, zero. Instantiated once in the EXEC path.

Test Plan:
- Stack model with stk_done 1 cycle after the request. PUSHI 0x05, PUSHI 0x03, ADD -> pushes 0x05 then 0x03, two pops, push 0x08; rsp_data 0x08, carry 0, depth 1.
- PUSHI 0xF0, PUSHI 0x20, ADD -> rsp_data 0x10, carry 1. Then PUSHI 0x11, SUB -> rsp_data 0xFF, carry 1 (borrow).
- From reset: POP -> rsp_err 1 with no stk_pop pulse. Fill to 128 with PUSHI, then one more PUSHI -> rsp_err 2, no stk_push, depth stays 128.
- Depth 1 holding 0x2A: DUP -> one pop, then two pushes of 0x2A, depth 2. POP twice -> 0x2A, 0x2A, then rsp_zero 0 and depth 0.
- Model never asserts stk_done after a PUSHI -> rsp_err 3 exactly TIMEOUT cycles after the request, fault 1, cmd_ready stuck at 0. Assert rst -> fault 0, cmd_ready 1, depth 0.
- Assert rst during POPB_WAIT of an ADD -> all outputs at reset values immediately (asynchronous), no rsp_valid. A spurious stk_done arriving while IDLE is ignored.
